ide_mgmt_arbiter: RTL and testbench

- Shares one host-side management port (HPS/OSD-style, 4-bit address, 16-bit data) between two IDE channel controllers, e.g. primary and secondary.
- Watches each channel's 3-bit service request.
- Grants the host to one channel at a time, round-robin, and routes mgmt strobes, address and data to the granted channel only.
- Holds the grant until the channel's request clears or an inactivity timeout fires.

---
 rtl/ide_mgmt_arbiter.sv | 141 ++++++++++++++
 tb/tb_ide_mgmt_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ide_mgmt_arbiter.sv
// Round-robin arbiter sharing one host management port between two IDE channels.
// Grant is held until the channel's request clears or the host goes idle too long.

module ide_mgmt_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic wr,
  input  logic rd,
  output logic mgmt_write,
  output logic mgmt_read
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mgmt_write <= 1'b0;
      mgmt_read  <= 1'b0;
    end else begin
      mgmt_write <= en & wr;
      mgmt_read  <= en & rd;
    end
  end
endmodule

module ide_mgmt_arbiter #(
  parameter int              TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  ch_request0,
  input  logic [2:0]  ch_request1,
  output logic [3:0]  mgmt_address,
  output logic [15:0] mgmt_writedata,
  output logic [1:0]  mgmt_write,
  output logic [1:0]  mgmt_read,
  input  logic [15:0] mgmt_readdata0,
  input  logic [15:0] mgmt_readdata1,
  input  logic [3:0]  host_address,
  input  logic        host_write,
  input  logic [15:0] host_writedata,
  input  logic        host_read,
  output logic [15:0] host_readdata,
  output logic        host_irq,
  output logic        host_chan,
  output logic [2:0]  host_request,
  output logic        timeout
);
  localparam int NUM_CH = 2;

  typedef enum logic [1:0] {IDLE, LOCK, DRAIN} state_t;

  state_t                  state;
  logic                    last_served;
  logic [TO_W-1:0]         to_cnt;
  logic [NUM_CH-1:0][2:0]  req_q;
  logic [NUM_CH-1:0]       chan_en;
  logic                    fwd;
  logic                    grant_ch;
  logic                    any_req;

  // Strobes pass through during DRAIN too, so the channel sees each falling edge.
  assign fwd = (state != IDLE);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      assign chan_en[g] = fwd && (host_chan == g[0]);
      ide_mgmt_strobe u_strobe (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (chan_en[g]),
        .wr         (host_write),
        .rd         (host_read),
        .mgmt_write (mgmt_write[g]),
        .mgmt_read  (mgmt_read[g])
      );
    end
  endgenerate

  always_comb begin
    any_req  = (|req_q[0]) || (|req_q[1]);
    grant_ch = ((|req_q[0]) && (|req_q[1])) ? ~last_served : (|req_q[1]);
    host_readdata = 16'hFFFF;
    if (state != IDLE)
      host_readdata = host_chan ? mgmt_readdata1 : mgmt_readdata0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_served    <= 1'b1;
      to_cnt         <= '0;
      req_q          <= '0;
      host_chan      <= 1'b0;
      host_request   <= 3'b000;
      host_irq       <= 1'b0;
      timeout        <= 1'b0;
      mgmt_address   <= 4'h0;
      mgmt_writedata <= 16'h0000;
    end else begin
      req_q   <= {ch_request1, ch_request0};
      timeout <= 1'b0;
      if (fwd) begin
        mgmt_address   <= host_address;
        mgmt_writedata <= host_writedata;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            host_chan    <= grant_ch;
            host_request <= req_q[grant_ch];
            host_irq     <= 1'b1;
            to_cnt       <= '0;
            state        <= LOCK;
          end
        end
        LOCK: begin
          host_request <= req_q[host_chan];
          host_irq     <= |req_q[host_chan];
          if (host_write || host_read) to_cnt <= '0;
          else if (to_cnt != '1)       to_cnt <= to_cnt + 1'b1;
          if (req_q[host_chan] == 3'b000) begin
            state <= DRAIN;
          end else if (to_cnt == TIMEOUT) begin
            state   <= DRAIN;
            timeout <= 1'b1;
          end
        end
        DRAIN: begin
          if (!host_write && !host_read && !(|mgmt_write) && !(|mgmt_read)) begin
            last_served  <= host_chan;
            host_irq     <= 1'b0;
            host_request <= 3'b000;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ide_mgmt_arbiter.sv
// Directed bench for ide_mgmt_arbiter with a 16-cycle inactivity timeout.

module tb_ide_mgmt_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ch_request0, ch_request1;
  logic [3:0]  mgmt_address;
  logic [15:0] mgmt_writedata;
  logic [1:0]  mgmt_write, mgmt_read;
  logic [15:0] mgmt_readdata0, mgmt_readdata1;
  logic [3:0]  host_address;
  logic        host_write, host_read;
  logic [15:0] host_writedata, host_readdata;
  logic        host_irq, host_chan, timeout;
  logic [2:0]  host_request;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ide_mgmt_arbiter #(.TO_W(24), .TIMEOUT(24'd16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_request0(ch_request0), .ch_request1(ch_request1),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
    .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
    .mgmt_readdata0(mgmt_readdata0), .mgmt_readdata1(mgmt_readdata1),
    .host_address(host_address), .host_write(host_write),
    .host_writedata(host_writedata), .host_read(host_read),
    .host_readdata(host_readdata), .host_irq(host_irq),
    .host_chan(host_chan), .host_request(host_request), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bad;
    int pulses;
    rst_n = 1'b0; ch_request0 = 3'b000; ch_request1 = 3'b000;
    host_address = 4'h0; host_write = 1'b0; host_read = 1'b0; host_writedata = 16'h0;
    mgmt_readdata0 = 16'h1234; mgmt_readdata1 = 16'hBEEF;
    step(2);
    chk("rst_irq",   host_irq, 0);
    chk("rst_chan",  host_chan, 0);
    chk("rst_req",   host_request, 0);
    chk("rst_strb",  {mgmt_write, mgmt_read}, 0);
    chk("rst_to",    timeout, 0);
    chk("rst_rdata", host_readdata, 16'hFFFF);
    chk("rst_addr",  {mgmt_address, mgmt_writedata}, 0);
    rst_n = 1'b1;
    step();

    // Host read with no grant is dropped.
    host_read = 1'b1;
    step();
    chk("idle_rd_strb",  mgmt_read, 2'b00);
    chk("idle_rd_rdata", host_readdata, 16'hFFFF);
    host_read = 1'b0;

    // Single request on ch0: grant two edges after it appears.
    ch_request0 = 3'b100;
    step();
    chk("grant_early", host_irq, 0);
    step();
    chk("grant0", {host_irq, host_chan, host_request}, {1'b1, 1'b0, 3'b100});
    host_address = 4'h5; host_write = 1'b1; host_writedata = 16'hA5A5;
    step();
    chk("wr0_strb", mgmt_write, 2'b01);
    chk("wr0_addr", {mgmt_address, mgmt_writedata}, {4'h5, 16'hA5A5});
    host_write = 1'b0;
    step();
    chk("wr0_fall", mgmt_write, 2'b00);
    chk("rdata0", host_readdata, 16'h1234);

    // Nonzero-to-nonzero change keeps the grant; ch1 request must wait.
    ch_request0 = 3'b101; ch_request1 = 3'b010;
    step(2);
    chk("req_upd", {host_irq, host_chan, host_request}, {1'b1, 1'b0, 3'b101});

    // Release ch0: req_q, LOCK->DRAIN, DRAIN->IDLE, then grant ch1.
    ch_request0 = 3'b000;
    step(3);
    chk("drained_idle", host_readdata, 16'hFFFF);
    step();
    chk("grant1", {host_irq, host_chan, host_request}, {1'b1, 1'b1, 3'b010});

    // Stream 256 single-cycle writes at address F to ch1.
    bad = 0; pulses = 0;
    host_address = 4'hF;
    for (int i = 0; i < 256; i++) begin
      host_write = 1'b1; host_writedata = 16'(i * 7 + 3);
      step();
      if (mgmt_write == 2'b10) pulses++;
      if (mgmt_write != 2'b10 || mgmt_address != 4'hF || mgmt_writedata != 16'(i * 7 + 3)) bad++;
      host_write = 1'b0;
      step();
      if (mgmt_write != 2'b00) bad++;
    end
    chk("stream_bad", bad, 0);
    chk("stream_pulses", pulses, 256);

    // Request clears while host_read still high: stay in DRAIN on ch1.
    host_read = 1'b1;
    step();
    chk("rd1_strb", mgmt_read, 2'b10);
    ch_request1 = 3'b000; ch_request0 = 3'b100;
    step(4);
    chk("drain_hold", {host_chan, mgmt_read, host_readdata}, {1'b1, 2'b10, 16'hBEEF});
    host_read = 1'b0;
    step();
    chk("drain_fall", {host_chan, mgmt_read, host_readdata}, {1'b1, 2'b00, 16'hBEEF});
    step();
    chk("drain_exit", {host_irq, host_readdata}, {1'b0, 16'hFFFF});
    step();
    chk("grant0b", {host_irq, host_chan, host_request}, {1'b1, 1'b0, 3'b100});

    // Host idle in LOCK: timeout pulses on the 17th edge after grant.
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (timeout !== 1'b0 || host_irq !== 1'b1) bad++;
    end
    chk("to_quiet", bad, 0);
    ch_request1 = 3'b001;
    step();
    chk("to_pulse", timeout, 1);
    step();
    chk("to_idle", {timeout, host_irq, host_readdata}, {1'b0, 1'b0, 16'hFFFF});
    step();
    chk("rr_regrant", {host_irq, host_chan, host_request}, {1'b1, 1'b1, 3'b001});

    // Reset mid-transfer drops strobes at the next edge.
    host_write = 1'b1;
    step();
    chk("pre_rst_wr", mgmt_write, 2'b10);
    rst_n = 1'b0;
    step();
    chk("rst_lock", {mgmt_write, mgmt_read, host_irq, host_chan}, 0);
    host_write = 1'b0;

    // Simultaneous requests after reset: ch0 first, then ch1.
    ch_request0 = 3'b110; ch_request1 = 3'b110;
    rst_n = 1'b1;
    step(2);
    chk("both_grant0", {host_irq, host_chan, host_request}, {1'b1, 1'b0, 3'b110});
    ch_request0 = 3'b000;
    step(4);
    chk("both_grant1", {host_irq, host_chan, host_request}, {1'b1, 1'b1, 3'b110});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
